// File: rtl/halfduplex_msg_xfer_ctrl.sv
// rtl/halfduplex_msg_xfer_ctrl.sv - half-duplex message TX, turnaround and RX controller
// Define XFER_PARITY_EN to add an even-parity bit after TX and RX plus the parity_err output.
module halfduplex_msg_xfer_ctrl #(
  parameter int MSG_WIDTH   = 4,
  parameter int TURN_CYCLES = 1
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic [MSG_WIDTH-1:0] in_msg,
  input  logic                 in_rx_req,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 serial_out,
  output logic                 serial_oe,
  input  logic                 serial_in,
  output logic [MSG_WIDTH-1:0] out_msg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
`ifdef XFER_PARITY_EN
  ,
  output logic                 parity_err
`endif
);
  localparam int CNT_MAX = (MSG_WIDTH > TURN_CYCLES) ? MSG_WIDTH : TURN_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(MSG_WIDTH - 1);
  localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_TURN,
    S_RX,
    S_DONE
`ifdef XFER_PARITY_EN
    ,
    S_TX_PAR,
    S_RX_PAR
`endif
  } state_t;

  state_t               r_state;
  logic [MSG_WIDTH-1:0] r_shreg;
  logic [CW-1:0]        r_cnt;
  logic                 r_rx_req;
  logic                 r_in_ready;
  logic                 r_busy;
  logic                 r_oe;
  logic                 r_sout;
  logic [MSG_WIDTH-1:0] r_out_msg;
  logic                 r_out_valid;
  logic [MSG_WIDTH-1:0] w_rx_shift;

  assign w_rx_shift = {r_shreg[MSG_WIDTH-2:0], serial_in};

  assign in_ready   = r_in_ready;
  assign busy       = r_busy;
  assign serial_oe  = r_oe;
  assign serial_out = r_sout;
  assign out_msg    = r_out_msg;
  assign out_valid  = r_out_valid;

`ifdef XFER_PARITY_EN
  logic r_perr;
  assign parity_err = r_perr;
`endif

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_rx_req    <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_oe        <= 1'b0;
      r_sout      <= 1'b0;
      r_out_msg   <= '0;
      r_out_valid <= 1'b0;
`ifdef XFER_PARITY_EN
      r_perr      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_state    <= S_TX;
            r_shreg    <= in_msg;
            r_rx_req   <= in_rx_req;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_oe       <= 1'b1;
            r_sout     <= in_msg[MSG_WIDTH-1];
          end
        end
        S_TX: begin
          // Rotate rather than shift so the register still holds the message for the parity bit.
          r_shreg <= {r_shreg[MSG_WIDTH-2:0], r_shreg[MSG_WIDTH-1]};
          if (r_cnt == BIT_LAST) begin
            r_cnt <= '0;
`ifdef XFER_PARITY_EN
            r_state <= S_TX_PAR;
            r_sout  <= ^r_shreg;
`else
            r_oe   <= 1'b0;
            r_sout <= 1'b0;
            if (r_rx_req) begin
              r_state <= S_TURN;
            end else begin
              r_state    <= S_IDLE;
              r_busy     <= 1'b0;
              r_in_ready <= 1'b1;
            end
`endif
          end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_sout <= r_shreg[MSG_WIDTH-2];
          end
        end
`ifdef XFER_PARITY_EN
        S_TX_PAR: begin
          r_oe   <= 1'b0;
          r_sout <= 1'b0;
          if (r_rx_req) begin
            r_state <= S_TURN;
          end else begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b1;
          end
        end
`endif
        S_TURN: begin
          if (r_cnt == TURN_LAST) begin
            r_cnt   <= '0;
            r_state <= S_RX;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RX: begin
          r_shreg <= w_rx_shift;
          if (r_cnt == BIT_LAST) begin
            r_cnt <= '0;
`ifdef XFER_PARITY_EN
            r_state <= S_RX_PAR;
`else
            r_state     <= S_DONE;
            r_out_msg   <= w_rx_shift;
            r_out_valid <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef XFER_PARITY_EN
        S_RX_PAR: begin
          r_state     <= S_DONE;
          r_out_msg   <= r_shreg;
          r_out_valid <= 1'b1;
          r_perr      <= (^r_shreg) ^ serial_in;
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cnt       <= '0;
          r_oe        <= 1'b0;
          r_sout      <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_halfduplex_msg_xfer_ctrl.sv
// tb/tb_halfduplex_msg_xfer_ctrl.sv - bench for halfduplex_msg_xfer_ctrl (TURN_CYCLES 1 and 3)
// Honours XFER_PARITY_EN when the design is built with it.
module tb_halfduplex_msg_xfer_ctrl;
  localparam int W = 4;
`ifdef XFER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_msg;
  logic         in_rx_req;
  logic         in_valid;
  logic         out_ready;
  logic         in_ready   [2];
  logic         serial_out [2];
  logic         serial_oe  [2];
  logic         serial_in  [2];
  logic [W-1:0] out_msg    [2];
  logic         out_valid  [2];
  logic         busy       [2];
  logic         parity_err [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    halfduplex_msg_xfer_ctrl #(
      .MSG_WIDTH  (W),
      .TURN_CYCLES(g == 0 ? 1 : 3)
    ) u_dut (
      .sys_clk   (clk),
      .rst       (rst),
      .in_msg    (in_msg),
      .in_rx_req (in_rx_req),
      .in_valid  (in_valid),
      .in_ready  (in_ready[g]),
      .serial_out(serial_out[g]),
      .serial_oe (serial_oe[g]),
      .serial_in (serial_in[g]),
      .out_msg   (out_msg[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .busy      (busy[g])
`ifdef XFER_PARITY_EN
      ,
      .parity_err(parity_err[g])
`endif
    );
`ifndef XFER_PARITY_EN
    assign parity_err[g] = 1'b0;
`endif
  end

  // Model: m_k counts cycles since the accepting edge (cycle 1 = first TX bit), 0 = idle.
  int           m_k    [2];
  logic [W-1:0] m_msg  [2];
  logic [W-1:0] m_acc  [2];
  logic [W-1:0] m_out  [2];
  logic         m_rx   [2];
  logic         m_perr [2];
  logic [W-1:0] reply;
  logic         reply_par;

  function automatic int turn_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic int rx_start(input int g);
    return W + P + turn_of(g) + 1;
  endfunction

  function automatic int done_k(input int g);
    return rx_start(g) + W + P;
  endfunction

  function automatic logic sin_of(input int g, input int k);
    int rs;
    rs = rx_start(g);
    if (k >= rs && k < rs + W) return reply[W-1-(k-rs)];
    if (k == rs + W && P == 1) return reply_par;
    return 1'b1;
  endfunction

  initial begin
    for (int g = 0; g < 2; g++) begin
      m_k[g] = 0; m_msg[g] = '0; m_acc[g] = '0; m_out[g] = '0; m_rx[g] = 1'b0; m_perr[g] = 1'b0;
    end
    forever begin
      @(posedge clk or posedge rst);
      for (int g = 0; g < 2; g++) begin
        if (rst) begin
          m_k[g] = 0; m_out[g] = '0; m_perr[g] = 1'b0;
        end else if (m_k[g] == 0) begin
          if (in_valid) begin
            m_k[g] = 1; m_msg[g] = in_msg; m_rx[g] = in_rx_req;
          end
        end else begin
          if (m_k[g] >= rx_start(g) && m_k[g] < rx_start(g) + W)
            m_acc[g] = {m_acc[g][W-2:0], serial_in[g]};
          if (!m_rx[g] && m_k[g] == W + P) begin
            m_k[g] = 0;
          end else if (m_k[g] == done_k(g)) begin
            if (out_ready) m_k[g] = 0;
          end else begin
            if (m_k[g] == done_k(g) - 1) begin
              m_out[g] = m_acc[g];
              if (P == 1) m_perr[g] = (^m_acc[g]) ^ serial_in[g];
            end
            m_k[g] = m_k[g] + 1;
          end
        end
      end
    end
  end

  initial begin
    serial_in[0] = 1'b1;
    serial_in[1] = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      for (int g = 0; g < 2; g++) serial_in[g] = sin_of(g, m_k[g]);
    end
  end

  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", name, g, $time, act, exp);
    end
  endtask

  task automatic compare_loop();
    int   k;
    logic e_oe;
    logic e_so;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        k    = m_k[g];
        e_oe = (k >= 1) && (k <= W + P);
        e_so = 1'b0;
        if (e_oe) begin
          if (k <= W) e_so = m_msg[g][W-k];
          else        e_so = ^m_msg[g];
        end
        chk("in_ready",   g, 32'(in_ready[g]),   32'(k == 0));
        chk("busy",       g, 32'(busy[g]),       32'(k != 0));
        chk("serial_oe",  g, 32'(serial_oe[g]),  32'(e_oe));
        chk("serial_out", g, 32'(serial_out[g]), 32'(e_so));
        chk("out_valid",  g, 32'(out_valid[g]),  32'(m_rx[g] && k == done_k(g)));
        chk("out_msg",    g, 32'(out_msg[g]),    32'(m_out[g]));
`ifdef XFER_PARITY_EN
        chk("parity_err", g, 32'(parity_err[g]), 32'(m_perr[g]));
`endif
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic launch(input logic [W-1:0] msg, input logic rx);
    step();
    in_msg = msg; in_rx_req = rx; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Measures, per instance, the cycle of first out_valid and the driven/released cycles before it.
  task automatic run_xfer(input logic [W-1:0] msg,
                          output int lat0, output int lat1,
                          output int oe0, output int oe1, output int gap0, output int gap1);
    lat0 = 0; lat1 = 0; oe0 = 0; oe1 = 0; gap0 = 0; gap1 = 0;
    launch(msg, 1'b1);
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (lat0 == 0) begin
        if (out_valid[0]) lat0 = n; else if (serial_oe[0]) oe0++; else gap0++;
      end
      if (lat1 == 0) begin
        if (out_valid[1]) lat1 = n; else if (serial_oe[1]) oe1++; else gap1++;
      end
      if (lat0 != 0 && lat1 != 0) break;
      step();
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(in_ready[0] && in_ready[1]) && n < 60) begin
      step();
      n++;
    end
    chk("idle_reached", 0, 32'(n < 60), 32'd1);
    if (n >= 60) begin
      rst = 1'b1; step(); rst = 1'b0;
    end
  endtask

  int lat0, lat1, oe0, oe1, gap0, gap1, ndrv;
  logic [W-1:0] bits;

  initial begin
    in_msg = '0; in_rx_req = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    reply = '0; reply_par = 1'b0;
    fork
      compare_loop();
    join_none
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 0, 32'(in_ready[0]), 32'd1);
    chk("rst_busy",     0, 32'(busy[0]),     32'd0);
    chk("rst_oe",       1, 32'(serial_oe[1]), 32'd0);
    chk("rst_out_msg",  0, 32'(out_msg[0]),  32'h0);

    // TX only: 1011 on the line, then release and ready.
    launch(4'b1011, 1'b0);
    bits = '0; ndrv = 0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      bits = {bits[W-2:0], serial_out[0]};
      ndrv += int'(serial_oe[0]);
      step();
    end
    if (P == 1) step();
    @(negedge clk);
    chk("t1_bits",      0, 32'(bits), 32'b1011);
    chk("t1_oe_cycles", 0, 32'(ndrv), 32'd4);
    chk("t1_oe_after",  0, 32'(serial_oe[0]), 32'd0);
    chk("t1_ready",     0, 32'(in_ready[0]),  32'd1);
    chk("t1_ready",     1, 32'(in_ready[1]),  32'd1);

    // TX 0xA then receive 0110; T=1 and T=3 latencies and gaps.
    reply = 4'h6; reply_par = 1'b0; out_ready = 1'b1;
    run_xfer(4'hA, lat0, lat1, oe0, oe1, gap0, gap1);
    chk("t2_latency", 0, 32'(lat0), 32'(10 + 2 * P));
    chk("t2_latency", 1, 32'(lat1), 32'(12 + 2 * P));
    chk("t2_out_msg", 0, 32'(out_msg[0]), 32'h6);
    chk("t2_out_msg", 1, 32'(out_msg[1]), 32'h6);
    chk("t5_oe_cycles", 1, 32'(oe1), 32'(4 + P));
    chk("t5_gap_cycles", 0, 32'(gap0), 32'(1 + 4 + P));
    chk("t5_gap_cycles", 1, 32'(gap1), 32'(3 + 4 + P));
    chk("t2_pulse", 0, 32'(out_valid[0]), 32'd0);
    wait_idle();

    // Consumer stalls for 5 cycles; in_valid pulses must be ignored.
    reply = 4'h9; out_ready = 1'b0;
    run_xfer(4'h5, lat0, lat1, oe0, oe1, gap0, gap1);
    chk("t3_reached", 1, 32'(lat1 != 0), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      in_valid = 1'b1; in_msg = 4'hF; in_rx_req = 1'b0;
      @(negedge clk);
      chk("t3_hold_valid", 0, 32'(out_valid[0]), 32'd1);
      chk("t3_hold_msg",   1, 32'(out_msg[1]),   32'h9);
      chk("t3_busy",       0, 32'(busy[0]),      32'd1);
    end
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("t3_released", 0, 32'(out_valid[0]), 32'd0);
    chk("t3_idle",     1, 32'(in_ready[1]),  32'd1);
    chk("t3_retain",   0, 32'(out_msg[0]),   32'h9);
    wait_idle();

    // Reset in the middle of RX.
    reply = 4'h6;
    launch(4'hA, 1'b1);
    repeat (7) step();
    rst = 1'b1;
    #1;
    chk("t4_oe",        0, 32'(serial_oe[0]), 32'd0);
    chk("t4_out_valid", 0, 32'(out_valid[0]), 32'd0);
    chk("t4_ready",     0, 32'(in_ready[0]),  32'd1);
    chk("t4_busy",      1, 32'(busy[1]),      32'd0);
    step();
    rst = 1'b0;

    // Reset while driving: the line must be released before the next clock edge.
    launch(4'hF, 1'b0);
    @(negedge clk);
    chk("t4_tx_oe_pre", 0, 32'(serial_oe[0]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t4_tx_oe_async", 0, 32'(serial_oe[0]),  32'd0);
    chk("t4_tx_so_async", 1, 32'(serial_out[1]), 32'd0);
    step();
    rst = 1'b0;

    reply = 4'hC;
    run_xfer(4'h3, lat0, lat1, oe0, oe1, gap0, gap1);
    chk("t4_after_msg", 0, 32'(out_msg[0]), 32'hC);
    chk("t4_after_lat", 1, 32'(lat1), 32'(12 + 2 * P));
    wait_idle();

`ifdef XFER_PARITY_EN
    launch(4'b0111, 1'b0);
    bits = '0; ndrv = 0;
    for (int i = 0; i < W + 1; i++) begin
      @(negedge clk);
      bits = {bits[W-2:0], serial_out[0]};
      ndrv += int'(serial_oe[0]);
      step();
    end
    chk("t6_par_bit", 0, 32'(bits[0]), 32'd1);
    chk("t6_driven",  0, 32'(ndrv),    32'd5);
    wait_idle();
    reply = 4'h5; reply_par = 1'b1;
    run_xfer(4'h1, lat0, lat1, oe0, oe1, gap0, gap1);
    chk("t6_perr_set", 0, 32'(parity_err[0]), 32'd1);
    wait_idle();
    reply_par = 1'b0;
    run_xfer(4'h1, lat0, lat1, oe0, oe1, gap0, gap1);
    chk("t6_perr_clr", 0, 32'(parity_err[0]), 32'd0);
    wait_idle();
`endif

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
